// File: rtl/counter_register_pair.sv
// counter_register_pair: loadable up-counter and enable-gated register
// sharing clk/rst_n. The two halves are otherwise fully independent.
`timescale 1ns/1ps
module counter_register_pair #(
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] cnt_d,
  input  logic                 cnt_load,
  input  logic                 cnt_up,
  output logic [CNT_WIDTH-1:0] cnt_q,
  input  logic [REG_WIDTH-1:0] reg_d,
  input  logic                 reg_en,
  output logic [REG_WIDTH-1:0] reg_q
);

  // Reject zero-width instances at elaboration
  generate
    if (CNT_WIDTH == 0) begin : g_bad_cnt_width
      $error("counter_register_pair: CNT_WIDTH must be >= 1");
    end
    if (REG_WIDTH == 0) begin : g_bad_reg_width
      $error("counter_register_pair: REG_WIDTH must be >= 1");
    end
  endgenerate

  // Counter: load beats increment; increment wraps silently at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= cnt_d;
    end else if (cnt_up) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Register: capture reg_d only when enabled, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else if (reg_en) begin
      reg_q <= reg_d;
    end
  end

endmodule

// File: tb/tb_counter_register_pair.sv
// Scoreboard bench for counter_register_pair: a driver issues stimulus and
// pushes model predictions; independent monitors pop and compare.
`timescale 1ns/1ps
module tb_counter_register_pair;

  localparam int unsigned CW = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned CNT_MOD = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] cnt_d;
  logic          cnt_load;
  logic          cnt_up;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] reg_d;
  logic          reg_en;
  logic [RW-1:0] reg_q;

  counter_register_pair #(.CNT_WIDTH(CW), .REG_WIDTH(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt_d    (cnt_d),
    .cnt_load (cnt_load),
    .cnt_up   (cnt_up),
    .cnt_q    (cnt_q),
    .reg_d    (reg_d),
    .reg_en   (reg_en),
    .reg_q    (reg_q)
  );

  typedef struct {
    int    cnt;
    int    rg;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t async_q[$];
  event async_ev;

  int checks   = 0;
  int failures = 0;

  // Behavioural reference state: plain integers
  int m_cnt = 0;
  int m_reg = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic compare(input exp_t e);
    checks++;
    if (cnt_q !== CW'(e.cnt) || reg_q !== RW'(e.rg)) begin
      failures++;
      $display("FAIL %s: cnt_q=%0d (expected %0d) reg_q=0x%02h (expected 0x%02h) t=%0t",
               e.tag, cnt_q, e.cnt, reg_q, e.rg, $time);
    end
  endtask

  // Synchronous monitor: one prediction per rising edge, sampled 1ns after
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  // Asynchronous-reset monitor: checks outputs between clock edges
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      if (async_q.size() > 0) begin
        e = async_q.pop_front();
        compare(e);
      end
    end
  end

  // Drive one cycle at the falling edge and predict the post-edge outputs
  task automatic step(input logic r, input logic ld, input logic up,
                      input logic [CW-1:0] d, input logic en,
                      input logic [RW-1:0] rd, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    cnt_load = ld;
    cnt_up   = up;
    cnt_d    = d;
    reg_en   = en;
    reg_d    = rd;
    if (!r) begin
      m_cnt = 0;
      m_reg = 0;
    end else begin
      if (ld)      m_cnt = int'(d);
      else if (up) m_cnt = (m_cnt + 1) % CNT_MOD;
      if (en)      m_reg = int'(rd);
    end
    e.cnt = m_cnt;
    e.rg  = m_reg;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Pull reset low between edges and check outputs before the next edge
  task automatic async_rst(input string tag);
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_cnt = 0;
    m_reg = 0;
    e.cnt = 0;
    e.rg  = 0;
    e.tag = tag;
    async_q.push_back(e);
    #1;
    ->async_ev;
  endtask

  initial begin
    logic       ld;
    logic       up;
    logic       en;
    logic [CW-1:0] rd_cnt;
    logic [RW-1:0] rd_reg;

    rst_n    = 1'b0;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_d    = '0;
    reg_en   = 1'b0;
    reg_d    = '0;

    // Reset dominates active inputs over several edges
    repeat (4) step(1'b0, 1'b1, 1'b1, CW'(5), 1'b1, 8'hA5, "reset_hold");

    // Load values, then reset between edges
    step(1'b1, 1'b1, 1'b0, CW'(9), 1'b1, 8'h11, "pre_async_load");
    step(1'b1, 1'b0, 1'b1, CW'(2), 1'b0, 8'h77, "pre_async_inc");
    async_rst("async_reset_start");
    step(1'b0, 1'b1, 1'b1, CW'(6), 1'b1, 8'h99, "async_reset_hold");

    // Count and wrap: 1..15,0,1
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b0, 1'b1, CW'($urandom), 1'b0, RW'($urandom), "count_wrap");

    // Load priority over increment, then hold
    step(1'b1, 1'b1, 1'b0, CW'(7), 1'b0, 8'h00, "load_7");
    step(1'b1, 1'b1, 1'b1, CW'(3), 1'b0, 8'h00, "load_priority");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, CW'($urandom), 1'b0, RW'($urandom), "count_hold");

    // Slot-timer idiom: period-4 sequence 0,1,2,3,0,...
    step(1'b1, 1'b1, 1'b0, CW'(0), 1'b0, 8'h00, "slot_clear");
    for (int i = 0; i < 12; i++) begin
      ld = (m_cnt == 3);
      step(1'b1, ld, !ld, CW'(0), 1'b0, 8'h00, "slot_timer");
    end

    // Register enable and hold
    step(1'b1, 1'b0, 1'b0, CW'(0), 1'b1, 8'h3C, "reg_write_3c");
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, CW'(0), 1'b0, 8'hFF, "reg_hold");
    step(1'b1, 1'b0, 1'b0, CW'(0), 1'b1, 8'h00, "reg_write_0");

    // Independence: counting while register writes every other cycle
    step(1'b1, 1'b1, 1'b0, CW'(0), 1'b0, 8'h00, "indep_clear");
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 1'b1, CW'($urandom), (i % 2) == 0, RW'($urandom), "indep_run");
    async_rst("midop_reset");
    step(1'b0, 1'b0, 1'b1, CW'(0), 1'b1, 8'h5A, "midop_reset_hold");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, CW'($urandom), 1'b0, RW'($urandom), "resume_count");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_rst("rand_async_reset");
        step(1'b0, 1'b0, 1'b0, CW'($urandom), 1'b0, RW'($urandom), "rand_reset_hold");
      end else begin
        ld     = ($urandom_range(0, 5) == 0);
        up     = $urandom_range(0, 1) == 1;
        en     = $urandom_range(0, 1) == 1;
        rd_cnt = CW'($urandom);
        rd_reg = RW'($urandom);
        step(1'b1, ld, up, rd_cnt, en, rd_reg, "random");
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || async_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d (expected 0)",
               exp_q.size() + async_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_register_pair.md
Name: counter_register_pair

Overview:
- Pairs the two sequential primitives used across the networking layer: a loadable up-counter and an enable-gated register.
- The OPPM pulser and modulator use the counter for pulse-width, slot and symbol timing, and the register to latch modulator data.
- Both halves share clk/rst_n but are otherwise fully independent.
- Lets verification cover both primitives in one bench.

Parameters:
- CNT_WIDTH, 4, counter width in bits (>=1).
- REG_WIDTH, 8, register width in bits (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clock clk.
- cnt_d  input  CNT_WIDTH  counter load value.
- cnt_load  input  1  synchronous load/clear request.
- cnt_up  input  1  increment enable.
- cnt_q  output  CNT_WIDTH  current count.
- reg_d  input  REG_WIDTH  register data in.
- reg_en  input  1  register write enable.
- reg_q  output  REG_WIDTH  registered data.

Behaviour:
- Reset:
  - rst_n low forces cnt_q=0 and reg_q=0 immediately, without waiting for a clock edge.
  - Both stay 0 while rst_n is low; all other inputs are ignored.
- Counter:
  - Update rule, evaluated at each rising edge with rst_n high:
    - cnt_load=1: cnt_q <= cnt_d. Load has priority over up, so load=1 with up=1 loads.
    - cnt_load=0, cnt_up=1: cnt_q <= cnt_q+1, modulo 2^CNT_WIDTH (all-ones wraps to 0, no flag).
    - Both 0: hold.
  - cnt_q is a direct flop output, with no combinational path from any input; new value is visible one cycle after the request.
  - Clear idiom: cnt_d=0 with cnt_load=1 gives cnt_q=0 next cycle.
- Register:
  - reg_en=1 at a rising edge: reg_q <= reg_d.
  - reg_en=0: hold.
  - reg_q is a direct flop output; 1-cycle latency.
- Independence: counter controls never affect reg_q and vice versa; simultaneous activity on both halves in the same cycle is legal and each updates per its own rule.
- Reset mid-operation:
  - Asserting rst_n low between edges zeroes both outputs immediately.
  - After release, the first rising edge applies the normal rules starting from 0.
- No X propagation from unused inputs: cnt_d is ignored when cnt_load=0, and reg_d when reg_en=0.
- Implementation: pure synchronous RTL, two always_ff blocks with async reset, with parameter legality checks (width >=1) at elaboration.

Test Plan:
- Reset: drive cnt_load=1, cnt_d=5, reg_en=1, reg_d=8'hA5 while rst_n=0 over several edges -> cnt_q=0, reg_q=0 throughout; assert rst_n low between edges -> outputs drop to 0 before the next edge.
- Count and wrap: CNT_WIDTH=4, after reset hold cnt_up=1 for 17 cycles -> cnt_q goes 1,2,...,15,0,1.
- Load priority: cnt_q=7, apply cnt_load=1, cnt_up=1, cnt_d=3 -> cnt_q=3 next cycle; then load=0, up=0 for 3 cycles -> cnt_q stays 3.
- Slot-timer idiom: drive cnt_load=(cnt_q==3), cnt_up=(cnt_q!=3), cnt_d=0 -> cnt_q cycles 0,1,2,3,0,... with period 4.
- Register enable: reg_en=1, reg_d=8'h3C -> reg_q=8'h3C next cycle; reg_en=0, reg_d=8'hFF for 5 cycles -> reg_q stays 8'h3C; reg_en=1, reg_d=0 -> reg_q=0.
- Independence/mid-op reset: counter incrementing while the register toggles every other cycle -> each matches its own model; pulse rst_n low at count 9 -> both outputs 0, count resumes 1,2,... after release.
